muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: op_valid  in  1  EX stage holds a HI/LO-class instruction.
REQ-004 SHALL have: op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored.
REQ-005 SHALL have: rs_val, rt_val  in  32 each  operands.
REQ-006 SHALL have: pipe_adv  in  1  pipeline advances EX this cycle; ex_annul  in  1  flush of the EX instruction.
REQ-007 SHALL have: stall  out  1  hold pipeline; busy  out  1  FSM not IDLE.
REQ-008 SHALL have: hi, lo  out  32 each  architectural HI/LO.
REQ-009 SHALL have: mul_start, mul_signed  out  1; mul_a, mul_b  out  32; mul_ready  in  1; mul_result  in  64.
REQ-010 SHALL have: div_start, div_signed  out  1; div_a, div_b  out  32; div_ready  in  1; div_quot, div_rem  in  32.
REQ-011 SHALL have: unit_annul  out  1  abort both arithmetic units.

Function
REQ-012 SHALL implement FSM states IDLE, MUL_RUN, DIV_RUN, DONE.
REQ-013 IDLE, op_valid, op MULT/MULTU: SHALL latch operands and signedness (op[0]==0 signed), go MUL_RUN next cycle, assert stall combinationally that same cycle.
REQ-014 IDLE, op_valid, op DIV/DIVU, rt_val!=0: SHALL likewise go DIV_RUN.
REQ-015 DIV/DIVU with rt_val==0: SHALL not start the divider, leave HI/LO unchanged, not stall.
REQ-016 MUL_RUN/DIV_RUN: the unit's start SHALL be held high continuously from latched registers; stall=1.
REQ-017 mul_ready sampled 1 in MUL_RUN: SHALL write {hi,lo}<=mul_result, drop mul_start, go DONE.
REQ-018 div_ready sampled 1 in DIV_RUN: SHALL write lo<=div_quot, hi<=div_rem, drop div_start, go DONE.
REQ-019 DONE: stall=0; SHALL go IDLE when pipe_adv=1, else hold DONE without restarting any unit.
REQ-020 IDLE, op_valid, pipe_adv, op MTHI/MTLO: SHALL write hi or lo <= rs_val at that edge, no stall, state unchanged.
REQ-021 Unit outputs SHALL be ignored outside the matching RUN state; at most one start asserted at any time.
REQ-022 ex_annul=1 in any state: SHALL drive unit_annul=1 for that cycle, deassert starts, go IDLE next edge, suppress any HI/LO write that edge (annul beats ready).
REQ-023 stall SHALL be 0 whenever ex_annul=1.
REQ-024 No restart SHALL occur in the cycle ex_annul is high even if op_valid=1.

Reset
REQ-025 rst SHALL force IDLE, hi=lo=0, operand/signed registers 0, all starts 0, stall=0, busy=0.
REQ-026 unit_annul SHALL be 1 while rst is high so units are flushed identically.
REQ-027 rst mid-operation SHALL discard the pending result; no HI/LO write after reset release.

Structure
REQ-028 Op encodings (3-bit) and state encodings SHALL live in the shared CPU package.
REQ-029 The SHALL be no sub-module; the arithmetic units remain external instances wired by the top.

Verification
REQ-030 MULT rs=0xFFFFFFFE, rt=3, unit ready after 2 cycles -> stall for RUN cycles, hi=0xFFFFFFFF, lo=0xFFFFFFFA, stall drops in DONE.
REQ-031 DIVU rs=100, rt=7 -> lo=14, hi=2; DONE held 3 cycles with pipe_adv=0 -> div_start never re-asserted.
REQ-032 DIV rs=5, rt=0 -> no div_start, stall=0, hi/lo unchanged.
REQ-033 MULTU 0x10000*0x10000, ex_annul same cycle as mul_ready -> unit_annul=1, hi/lo unchanged, IDLE next cycle.
REQ-034 MTHI rs=0xDEADBEEF then MTLO rs=0x12345678 back-to-back with pipe_adv=1 -> hi=0xDEADBEEF, lo=0x12345678, stall never 1.
REQ-035 rst asserted during DIV_RUN -> immediate IDLE, hi=lo=0, starts 0, unit_annul=1 until release.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// rtl/muldiv_ctrl_pkg.sv - HI/LO op and controller state encodings
package muldiv_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DIV_RUN = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Even op codes in the arithmetic group are the signed variants.
  function automatic logic op_is_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - HI/LO sequencing for external multiply and divide units
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        pipe_adv,
  input  logic        ex_annul,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        mul_start,
  output logic        mul_signed,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_ready,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_ready,
  input  logic [31:0] div_quot,
  input  logic [31:0] div_rem,
  output logic        unit_annul
);

  state_e      state;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        sgn_q;
  logic        is_mul;
  logic        is_div;
  logic        running;

  assign is_mul  = op_valid && (op == OP_MULT || op == OP_MULTU);
  // Divide by zero never launches the divider; HI/LO keep their old values.
  assign is_div  = op_valid && (op == OP_DIV || op == OP_DIVU) && (rt_val != 32'd0);
  assign running = (state == ST_MUL_RUN) || (state == ST_DIV_RUN);

  assign stall = !rst && !ex_annul &&
                 (running || (state == ST_IDLE && (is_mul || is_div)));
  assign busy       = (state != ST_IDLE);
  assign unit_annul = rst || ex_annul;

  assign mul_start  = (state == ST_MUL_RUN) && !ex_annul;
  assign div_start  = (state == ST_DIV_RUN) && !ex_annul;
  assign mul_signed = sgn_q;
  assign div_signed = sgn_q;
  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign div_a      = a_q;
  assign div_b      = b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      hi    <= 32'd0;
      lo    <= 32'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      sgn_q <= 1'b0;
    end else if (ex_annul) begin
      // Annul wins over any ready or issue arriving in the same cycle.
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_mul || is_div) begin
            a_q   <= rs_val;
            b_q   <= rt_val;
            sgn_q <= op_is_signed(op);
            state <= is_mul ? ST_MUL_RUN : ST_DIV_RUN;
          end else if (op_valid && pipe_adv && op == OP_MTHI) begin
            hi <= rs_val;
          end else if (op_valid && pipe_adv && op == OP_MTLO) begin
            lo <= rs_val;
          end
        end
        ST_MUL_RUN: begin
          if (mul_ready) begin
            {hi, lo} <= mul_result;
            state    <= ST_DONE;
          end
        end
        ST_DIV_RUN: begin
          if (div_ready) begin
            lo    <= div_quot;
            hi    <= div_rem;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (pipe_adv) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed vector bench for muldiv_ctrl
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        pipe_adv, ex_annul;
  logic        stall, busy;
  logic [31:0] hi, lo;
  logic        mul_start, mul_signed, mul_ready;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_result;
  logic        div_start, div_signed, div_ready;
  logic [31:0] div_a, div_b, div_quot, div_rem;
  logic        unit_annul;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .pipe_adv(pipe_adv), .ex_annul(ex_annul),
    .stall(stall), .busy(busy), .hi(hi), .lo(lo),
    .mul_start(mul_start), .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ready(mul_ready), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed), .div_a(div_a), .div_b(div_b),
    .div_ready(div_ready), .div_quot(div_quot), .div_rem(div_rem),
    .unit_annul(unit_annul)
  );

  typedef struct {
    logic        valid;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        adv;
    logic        annul;
    logic        exp_stall;
    logic        exp_busy;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    op_valid = 1'b0; op = 3'b000; rs_val = '0; rt_val = '0;
    pipe_adv = 1'b0; ex_annul = 1'b0;
    mul_ready = 1'b0; mul_result = '0;
    div_ready = 1'b0; div_quot = '0; div_rem = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    // Reset state, with op_valid high to show reset overrides an issue.
    @(negedge clk);
    op_valid = 1'b1; op = 3'b000; rt_val = 32'd3;
    #1;
    chk("rst stall", stall, 0);
    chk("rst busy", busy, 0);
    chk("rst hi", hi, 0);
    chk("rst lo", lo, 0);
    chk("rst mul_start", mul_start, 0);
    chk("rst div_start", div_start, 0);
    chk("rst unit_annul", unit_annul, 1);
    chk("rst mul_a", mul_a, 0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    #1 chk("post-rst unit_annul", unit_annul, 0);

    //          valid op      rs            rt     adv annul stall busy hi            lo
    vecs[0] = '{1, 3'b100, 32'hDEADBEEF, 32'd0, 1, 0, 0, 0, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1, 3'b101, 32'h12345678, 32'd0, 1, 0, 0, 0, 32'hDEADBEEF, 32'h12345678};
    vecs[2] = '{1, 3'b100, 32'h0000AAAA, 32'd0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h12345678};
    vecs[3] = '{1, 3'b010, 32'd5,        32'd0, 1, 0, 0, 0, 32'hDEADBEEF, 32'h12345678};
    vecs[4] = '{1, 3'b110, 32'd1,        32'd2, 1, 0, 0, 0, 32'hDEADBEEF, 32'h12345678};
    vecs[5] = '{1, 3'b111, 32'd1,        32'd2, 1, 0, 0, 0, 32'hDEADBEEF, 32'h12345678};
    vecs[6] = '{1, 3'b101, 32'h55555555, 32'd0, 1, 1, 0, 0, 32'hDEADBEEF, 32'h12345678};
    vecs[7] = '{1, 3'b000, 32'd4,        32'd4, 1, 1, 0, 0, 32'hDEADBEEF, 32'h12345678};
    vecs[8] = '{1, 3'b011, 32'd9,        32'd3, 0, 0, 1, 1, 32'hDEADBEEF, 32'h12345678};
    vecs[9] = '{0, 3'b101, 32'h66666666, 32'd0, 1, 0, 0, 0, 32'hDEADBEEF, 32'h12345678};

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      op_valid = vecs[i].valid; op = vecs[i].op;
      rs_val = vecs[i].rs; rt_val = vecs[i].rt;
      pipe_adv = vecs[i].adv; ex_annul = vecs[i].annul;
      #1;
      chk($sformatf("vec%0d stall", i), stall, vecs[i].exp_stall);
      chk($sformatf("vec%0d unit_annul", i), unit_annul, vecs[i].annul);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
      chk($sformatf("vec%0d hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("vec%0d lo", i), lo, vecs[i].exp_lo);
      chk($sformatf("vec%0d div_start", i), div_start, vecs[i].exp_busy && vecs[i].op == 3'b011);
      if (vecs[i].exp_busy) begin
        @(negedge clk);
        idle_inputs();
        ex_annul = 1'b1;
        #1 chk($sformatf("vec%0d recover start", i), div_start, 0);
        @(posedge clk);
        #1 chk($sformatf("vec%0d recover busy", i), busy, 0);
      end
    end

    // MULT -2 * 3, ready on the second RUN cycle; a stray div_ready must be ignored.
    @(negedge clk);
    idle_inputs();
    op_valid = 1'b1; op = 3'b000; rs_val = 32'hFFFFFFFE; rt_val = 32'd3;
    #1 chk("mult issue stall", stall, 1);
    @(posedge clk);
    @(negedge clk);
    div_ready = 1'b1; div_quot = 32'hBAD0BAD0; div_rem = 32'hBAD1BAD1;
    #1;
    chk("mult run1 stall", stall, 1);
    chk("mult mul_start", mul_start, 1);
    chk("mult div_start", div_start, 0);
    chk("mult mul_signed", mul_signed, 1);
    chk("mult operands", {mul_a, mul_b}, {32'hFFFFFFFE, 32'd3});
    @(negedge clk);
    div_ready = 1'b0;
    mul_ready = 1'b1; mul_result = 64'hFFFFFFFF_FFFFFFFA;
    #1;
    chk("mult run2 stall", stall, 1);
    chk("mult run2 hi unchanged", hi, 32'hDEADBEEF);
    @(negedge clk);
    mul_ready = 1'b0; mul_result = '0;
    #1;
    chk("mult done stall", stall, 0);
    chk("mult done mul_start", mul_start, 0);
    chk("mult done busy", busy, 1);
    chk("mult hi", hi, 32'hFFFFFFFF);
    chk("mult lo", lo, 32'hFFFFFFFA);
    pipe_adv = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1 chk("mult idle", busy, 0);

    // DIVU 100 / 7, then DONE held three cycles without pipe_adv.
    @(negedge clk);
    op_valid = 1'b1; op = 3'b011; rs_val = 32'd100; rt_val = 32'd7;
    #1 chk("divu issue stall", stall, 1);
    @(negedge clk);
    div_ready = 1'b1; div_quot = 32'd14; div_rem = 32'd2;
    #1;
    chk("divu div_start", div_start, 1);
    chk("divu mul_start", mul_start, 0);
    chk("divu div_signed", div_signed, 0);
    chk("divu operands", {div_a, div_b}, {32'd100, 32'd7});
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      div_ready = 1'b0;
      #1;
      chk($sformatf("divu done%0d div_start", c), div_start, 0);
      chk($sformatf("divu done%0d stall", c), stall, 0);
      chk($sformatf("divu done%0d busy", c), busy, 1);
    end
    chk("divu lo", lo, 32'd14);
    chk("divu hi", hi, 32'd2);
    pipe_adv = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1 chk("divu idle", busy, 0);

    // MULTU with ex_annul in the same cycle as mul_ready.
    @(negedge clk);
    op_valid = 1'b1; op = 3'b001; rs_val = 32'h10000; rt_val = 32'h10000;
    @(negedge clk);
    #1 chk("multu mul_signed", mul_signed, 0);
    mul_ready = 1'b1; mul_result = 64'h00000001_00000000; ex_annul = 1'b1;
    #1;
    chk("multu annul unit_annul", unit_annul, 1);
    chk("multu annul mul_start", mul_start, 0);
    chk("multu annul stall", stall, 0);
    @(posedge clk);
    #1;
    chk("multu annul busy", busy, 0);
    chk("multu annul hi", hi, 32'd2);
    chk("multu annul lo", lo, 32'd14);
    @(negedge clk);
    idle_inputs();

    // Reset during DIV_RUN, with ready pending across release.
    @(negedge clk);
    op_valid = 1'b1; op = 3'b010; rs_val = 32'hFFFFFFF9; rt_val = 32'd2;
    @(negedge clk);
    #1 chk("div run start", div_start, 1);
    rst = 1'b1;
    div_ready = 1'b1; div_quot = 32'hFFFFFFFD; div_rem = 32'hFFFFFFFF;
    #1;
    chk("div rst busy", busy, 0);
    chk("div rst hi", hi, 0);
    chk("div rst lo", lo, 0);
    chk("div rst div_start", div_start, 0);
    chk("div rst unit_annul", unit_annul, 1);
    chk("div rst stall", stall, 0);
    @(posedge clk);
    #1 chk("div rst held unit_annul", unit_annul, 1);
    @(negedge clk);
    rst = 1'b0;
    op_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("div post-rst hi", hi, 0);
    chk("div post-rst lo", lo, 0);
    chk("div post-rst busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
